acq_frame_sequencer: RTL
========================

Name: acq_frame_sequencer

Overview:
- Decodes host commands delivered from the USB controller's command word.
- Paces frame readouts by driving the USB controller's start_sending handshake.
  - One frame is 128 y/x sample pairs.
  - The number of frames and the spacing between them are programmable.
- Supervises each transfer with a timeout, so that a hung USB write cycle cannot stall acquisition.
- Sits between the command path (command word brought into the clk domain as cmd_data/cmd_valid) and the UsbController/front-end sample buffers.

Parameters:
- CMD_W, 16, width of the command word (opcode in [15:12], argument in [11:0]).
- COUNT_W, 12, width of the frame counter and the frame-count argument.
- INTERVAL_SHIFT, 8, scale of the interval: one interval unit = 2^INTERVAL_SHIFT clk cycles.
- TIMEOUT_CYCLES, 1048576, maximum number of cycles start_sending may stay high without xfer_done.

Ports:
- clk  input  1  system clock (same clk as the USB controller's buffer side).
- reset  input  1  asynchronous, active-low reset. This is already decided; the port keeps the codebase name "reset", and 0 = reset.
- cmd_data  input  CMD_W  host command; valid only when cmd_valid=1.
- cmd_valid  input  1  one-cycle strobe for a new host command.
- xfer_done  input  1  high while the USB controller has finished the frame upload and waits for start_sending to drop.
- start_sending  output  1  frame request to the USB controller (level, registered).
- acq_trigger  output  1  one-cycle pulse on every rising edge of start_sending; front end freezes the sample buffers.
- busy  output  1  high in every state except IDLE and ERROR.
- frames_done  output  COUNT_W  frames completed since the last START or SINGLE.
- timeout_err  output  1  sticky transfer-timeout flag.
- cmd_ignored  output  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset values (asynchronous): all outputs 0; state IDLE; interval_reg=0; count_reg=0; stop_pending=0.
- Opcodes:
  - 0 NOOP: no effect.
  - 1 START: arg = frame count; 0 = continuous.
  - 2 STOP.
  - 3 SET_INTERVAL: arg = interval units.
  - 4 SINGLE: exactly one frame; arg ignored.
  - Any other opcode: cmd_ignored pulse, no other effect.
- Command latency: command accepted at cycle t; its effect is visible on registered outputs at t+1.
- States and transitions:
  - IDLE:
    - START/SINGLE → REQ. In the same update: frames_done←0, count_reg←arg (SINGLE: count_reg←1), timeout_err←0.
    - If xfer_done=1 when START/SINGLE arrives, the command is rejected (cmd_ignored) and the state stays IDLE.
  - REQ:
    - start_sending=1. acq_trigger pulses in the first REQ cycle only.
    - Timeout counter loads TIMEOUT_CYCLES on entry and decrements each cycle.
    - xfer_done=1 → RELEASE, frames_done+1 (wraps modulo 2^COUNT_W).
    - Counter reaching 0 while xfer_done=0 → ERROR, with start_sending←0 and timeout_err←1.
    - If xfer_done rises in the same cycle the counter reaches 0, xfer_done wins.
  - RELEASE:
    - start_sending=0; wait for xfer_done=0.
    - When xfer_done=0:
      - Go to IDLE if stop_pending=1, or if count_reg≠0 and frames_done==count_reg. stop_pending is cleared on this exit.
      - Otherwise go to ARM.
  - ARM:
    - Interval counter loads interval_reg<<INTERVAL_SHIFT on entry.
    - Go to REQ when the counter is 0. Interval 0 → exactly one ARM cycle.
    - STOP in ARM → IDLE on the next cycle.
  - ERROR:
    - Outputs quiescent; timeout_err held.
    - START/SINGLE leave ERROR only when xfer_done=0, following the same rules as from IDLE. Otherwise they are rejected with cmd_ignored.
- STOP handling:
  - In REQ or RELEASE: sets stop_pending. The current frame always completes; start_sending never drops before xfer_done.
  - In IDLE or ERROR: no effect.
- START or SINGLE while busy: cmd_ignored pulse; state, count and frames_done unchanged.
- SET_INTERVAL: accepted in any state; takes effect at the next ARM entry.
- The first frame after START is not delayed by the interval.
- Reset asserted mid-frame: start_sending drops immediately. The USB controller recovers through its own return to wait-up.

Decomposition:
- Package acq_seq_pkg holds:
  - opcode constants: OP_NOOP, OP_START, OP_STOP, OP_SET_INTERVAL, OP_SINGLE;
  - state encodings: IDLE, REQ, RELEASE, ARM, ERROR;
  - field positions of the command word.
- Sub-module seq_down_timer: a loadable down-counter with zero flag, width parameterised. Two instances, one for the interval and one for the timeout.

Test Plan:
- SET_INTERVAL 2, then START 3, with xfer_done answered 10 cycles after each request → 3 acq_trigger pulses. Consecutive start_sending rising edges are 1+512 cycles apart after xfer_done falls. frames_done=3, busy=0, start_sending=0.
- START 0 (continuous), then STOP while in REQ → start_sending stays 1 until xfer_done rises, then falls. Afterwards state IDLE, no further trigger, frames_done = frames completed.
- TIMEOUT_CYCLES=64, START 1 with xfer_done held 0 → start_sending falls exactly 64 cycles after it rose, timeout_err=1, busy=0. Then hold xfer_done=1 and issue START → cmd_ignored pulses. Then drop xfer_done and issue START → timeout_err=0 and a new frame starts.
- Assert reset for 1 ns mid-REQ, between clock edges → all outputs 0 at once, without waiting for a clk edge. After release, SINGLE gives exactly one frame.
- START 5 while busy, and opcode 0xF → cmd_ignored pulse for each, with no state change. NOOP → no pulse.
- SET_INTERVAL 0, then START 2 → second start_sending rise occurs 2 cycles after xfer_done falls (RELEASE→ARM→REQ).

Source files
------------

// File: rtl/acq_seq_pkg.sv
// acq_seq_pkg
//   Shared definitions for the acquisition frame sequencer: command-word
//   field positions, host opcodes and the sequencer state encoding.
package acq_seq_pkg;

  // Command word layout: opcode in the top nibble, argument below it.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int ARG_MSB = 11;
  localparam int ARG_LSB = 0;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
  localparam int ARG_W   = ARG_MSB - ARG_LSB + 1;

  localparam logic [OPC_W-1:0] OP_NOOP         = 4'd0;
  localparam logic [OPC_W-1:0] OP_START        = 4'd1;
  localparam logic [OPC_W-1:0] OP_STOP         = 4'd2;
  localparam logic [OPC_W-1:0] OP_SET_INTERVAL = 4'd3;
  localparam logic [OPC_W-1:0] OP_SINGLE       = 4'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RELEASE = 3'd2,
    ARM     = 3'd3,
    ERROR   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/acq_frame_sequencer_timer.sv
// seq_down_timer
//   Loadable down-counter that stops at zero and flags it.
//   clk_i      : clock
//   rst_n_i    : asynchronous active-low reset (counter clears to 0)
//   load_i     : load load_val_i this cycle (has priority over counting)
//   load_val_i : value to load
//   zero_o     : counter currently holds 0
module seq_down_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/acq_frame_sequencer.sv
// acq_frame_sequencer
//   Decodes host commands and paces frame readouts through the USB
//   controller's start_sending / xfer_done handshake, with a programmable
//   frame count, inter-frame interval and a per-transfer timeout.
//   clk           : system clock
//   reset         : asynchronous active-low reset
//   cmd_data      : host command word (opcode [15:12], argument [11:0])
//   cmd_valid     : one-cycle command strobe
//   xfer_done     : USB controller finished the frame upload
//   start_sending : frame request level (registered)
//   acq_trigger   : one-cycle pulse on each start_sending rise
//   busy          : sequencer active (not IDLE / ERROR)
//   frames_done   : frames completed since the last START / SINGLE
//   timeout_err   : sticky transfer-timeout flag
//   cmd_ignored   : one-cycle pulse when a command is rejected
//
// state   | meaning
// IDLE    | waiting for START / SINGLE
// REQ     | start_sending high, waiting for xfer_done (timeout armed)
// RELEASE | start_sending low, waiting for xfer_done to drop
// ARM     | inter-frame interval countdown
// ERROR   | transfer timed out; waiting for a new START / SINGLE
module acq_frame_sequencer
  import acq_seq_pkg::*;
#(
  parameter int CMD_W          = 16,
  parameter int COUNT_W        = 12,
  parameter int INTERVAL_SHIFT = 8,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CMD_W-1:0]   cmd_data,
  input  logic               cmd_valid,
  input  logic               xfer_done,
  output logic               start_sending,
  output logic               acq_trigger,
  output logic               busy,
  output logic [COUNT_W-1:0] frames_done,
  output logic               timeout_err,
  output logic               cmd_ignored
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IVL_W = ARG_W + INTERVAL_SHIFT;

  seq_state_e         state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] frames_q, frames_d;
  logic [ARG_W-1:0]   interval_q, interval_d;
  logic               stop_q, stop_d;
  logic               terr_q, terr_d;
  logic               ign_q, ign_d;
  logic               ss_q;
  logic               trig_q;

  logic [OPC_W-1:0]   opc;
  logic [ARG_W-1:0]   arg;
  logic               cmd_start;
  logic               cmd_stop;
  logic               tmo_load, tmo_zero;
  logic               ivl_load, ivl_zero;
  logic [IVL_W-1:0]   ivl_span;
  logic [IVL_W-1:0]   ivl_load_val;

  assign opc       = cmd_data[OPC_MSB:OPC_LSB];
  assign arg       = cmd_data[ARG_MSB:ARG_LSB];
  assign cmd_start = cmd_valid && ((opc == OP_START) || (opc == OP_SINGLE));
  assign cmd_stop  = cmd_valid && (opc == OP_STOP);

  // Both timers are loaded one below the span and the FSM leaves on zero,
  // so the dwell is exactly the span (and a zero interval still costs one
  // ARM cycle).
  assign tmo_load     = (state_d == REQ) && (state_q != REQ);
  assign ivl_load     = (state_d == ARM) && (state_q != ARM);
  assign ivl_span     = {interval_q, {INTERVAL_SHIFT{1'b0}}};
  assign ivl_load_val = (ivl_span == '0) ? '0 : ivl_span - IVL_W'(1);

  seq_down_timer #(.W(TMO_W)) u_tmo_timer (
    .clk_i      (clk),
    .rst_n_i    (reset),
    .load_i     (tmo_load),
    .load_val_i (TMO_W'(TIMEOUT_CYCLES - 1)),
    .zero_o     (tmo_zero)
  );

  seq_down_timer #(.W(IVL_W)) u_ivl_timer (
    .clk_i      (clk),
    .rst_n_i    (reset),
    .load_i     (ivl_load),
    .load_val_i (ivl_load_val),
    .zero_o     (ivl_zero)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    frames_d   = frames_q;
    interval_d = interval_q;
    stop_d     = stop_q;
    terr_d     = terr_q;
    ign_d      = 1'b0;

    if (cmd_valid) begin
      case (opc)
        OP_NOOP, OP_START, OP_STOP, OP_SINGLE: ;
        OP_SET_INTERVAL: interval_d = arg;
        default:         ign_d = 1'b1;
      endcase
    end

    case (state_q)
      IDLE, ERROR: begin
        if (cmd_start) begin
          // A frame cannot be requested while the controller still holds
          // xfer_done from an earlier transfer.
          if (xfer_done) begin
            ign_d = 1'b1;
          end else begin
            state_d  = REQ;
            frames_d = '0;
            count_d  = (opc == OP_SINGLE) ? COUNT_W'(1) : COUNT_W'(arg);
            terr_d   = 1'b0;
            stop_d   = 1'b0;
          end
        end
      end
      REQ: begin
        if (cmd_start) ign_d = 1'b1;
        if (cmd_stop)  stop_d = 1'b1;
        if (xfer_done) begin
          state_d  = RELEASE;
          frames_d = frames_q + COUNT_W'(1);
        end else if (tmo_zero) begin
          state_d = ERROR;
          terr_d  = 1'b1;
          stop_d  = 1'b0;
        end
      end
      RELEASE: begin
        if (cmd_start) ign_d = 1'b1;
        if (cmd_stop)  stop_d = 1'b1;
        if (!xfer_done) begin
          if (stop_q || cmd_stop ||
              ((count_q != '0) && (frames_q == count_q))) begin
            state_d = IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = ARM;
          end
        end
      end
      ARM: begin
        if (cmd_start) ign_d = 1'b1;
        if (cmd_stop) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end else if (ivl_zero) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      frames_q   <= '0;
      interval_q <= '0;
      stop_q     <= 1'b0;
      terr_q     <= 1'b0;
      ign_q      <= 1'b0;
      ss_q       <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      frames_q   <= frames_d;
      interval_q <= interval_d;
      stop_q     <= stop_d;
      terr_q     <= terr_d;
      ign_q      <= ign_d;
      ss_q       <= (state_d == REQ);
      trig_q     <= (state_d == REQ) && (state_q != REQ);
    end
  end

  assign start_sending = ss_q;
  assign acq_trigger   = trig_q;
  assign busy          = (state_q != IDLE) && (state_q != ERROR);
  assign frames_done   = frames_q;
  assign timeout_err   = terr_q;
  assign cmd_ignored   = ign_q;

endmodule
